// File: rtl/dual_port_mem_arbiter.sv
// Four-requester, two-port scheduler for a 64x8 dual-port memory with a fixed two-cycle read return.
// Define DPM_ARB_RR_EN for round-robin selection; otherwise requester 0 has the highest priority.
module dual_port_mem_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 6,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic [DW-1:0]      mem_data_a,
    output logic [DW-1:0]      mem_data_b,
    output logic [AW-1:0]      mem_addr_a,
    output logic [AW-1:0]      mem_addr_b,
    output logic               mem_we_a,
    output logic               mem_we_b,
    input  logic [DW-1:0]      mem_q_a,
    input  logic [DW-1:0]      mem_q_b
);

    function automatic logic [AW-1:0] addr_sel(input logic [NREQ*AW-1:0] v, input logic [1:0] i);
        return v[AW*int'(i) +: AW];
    endfunction

    function automatic logic [DW-1:0] data_sel(input logic [NREQ*DW-1:0] v, input logic [1:0] i);
        return v[DW*int'(i) +: DW];
    endfunction

    logic [NREQ-1:0] gnt_q, gnt_d, elig_s;
    logic            a_found_s, b_found_s, b_go_s;
    logic [1:0]      a_idx_s, b_idx_s, scan_s;
    logic [AW-1:0]   a_addr_s, b_addr_s;
    logic [DW-1:0]   a_wdata_s, b_wdata_s;
    logic            a_we_s, b_we_s;
    logic [DW-1:0]   mem_data_a_q, mem_data_a_d, mem_data_b_q, mem_data_b_d;
    logic [AW-1:0]   mem_addr_a_q, mem_addr_a_d, mem_addr_b_q, mem_addr_b_d;
    logic            mem_we_a_q, mem_we_a_d, mem_we_b_q, mem_we_b_d;
    // Owner tags: [3] valid, [2] is-read, [1:0] requester index.
    logic [3:0]      tag_a_q, tag_a_d, tag_b_q, tag_b_d, tag2_a_q, tag2_b_q;
    logic [NREQ-1:0] rvalid_s;
    logic [NREQ*DW-1:0] rdata_s;
`ifdef DPM_ARB_RR_EN
    logic [1:0]      ptr_q, ptr_d;
`endif

    // Scan eligible requesters: first hit goes to port A, the next one to port B.
    always_comb begin
        elig_s    = req & ~gnt_q;
        a_found_s = 1'b0;
        b_found_s = 1'b0;
        a_idx_s   = 2'd0;
        b_idx_s   = 2'd0;
        scan_s    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef DPM_ARB_RR_EN
            scan_s = ptr_q + 2'(k);
`else
            scan_s = 2'(k);
`endif
            b_idx_s   = (elig_s[scan_s] && a_found_s && !b_found_s) ? scan_s : b_idx_s;
            b_found_s = b_found_s || (elig_s[scan_s] && a_found_s);
            a_idx_s   = (elig_s[scan_s] && !a_found_s) ? scan_s : a_idx_s;
            a_found_s = a_found_s || elig_s[scan_s];
        end
    end

    // Candidate operands, same-address write collision, and next register values.
    always_comb begin
        a_addr_s  = addr_sel(req_addr, a_idx_s);
        b_addr_s  = addr_sel(req_addr, b_idx_s);
        a_wdata_s = data_sel(req_wdata, a_idx_s);
        b_wdata_s = data_sel(req_wdata, b_idx_s);
        a_we_s    = req_we[a_idx_s];
        b_we_s    = req_we[b_idx_s];
        b_go_s    = b_found_s && !((a_addr_s == b_addr_s) && (a_we_s || b_we_s));
        for (int i = 0; i < NREQ; i++) begin
            gnt_d[i] = (a_found_s && (a_idx_s == 2'(i))) || (b_go_s && (b_idx_s == 2'(i)));
        end
        mem_we_a_d   = a_found_s && a_we_s;
        mem_addr_a_d = a_found_s ? a_addr_s : {AW{1'b0}};
        mem_data_a_d = a_found_s ? a_wdata_s : {DW{1'b0}};
        mem_we_b_d   = b_go_s && b_we_s;
        mem_addr_b_d = b_go_s ? b_addr_s : {AW{1'b0}};
        mem_data_b_d = b_go_s ? b_wdata_s : {DW{1'b0}};
        tag_a_d      = a_found_s ? {1'b1, !a_we_s, a_idx_s} : 4'd0;
        tag_b_d      = b_go_s ? {1'b1, !b_we_s, b_idx_s} : 4'd0;
    end

    // Grant, memory-side and owner-tag pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= {NREQ{1'b0}};
            mem_we_a_q   <= 1'b0;
            mem_addr_a_q <= {AW{1'b0}};
            mem_data_a_q <= {DW{1'b0}};
            mem_we_b_q   <= 1'b0;
            mem_addr_b_q <= {AW{1'b0}};
            mem_data_b_q <= {DW{1'b0}};
            tag_a_q      <= 4'd0;
            tag_b_q      <= 4'd0;
            tag2_a_q     <= 4'd0;
            tag2_b_q     <= 4'd0;
        end else begin
            gnt_q        <= gnt_d;
            mem_we_a_q   <= mem_we_a_d;
            mem_addr_a_q <= mem_addr_a_d;
            mem_data_a_q <= mem_data_a_d;
            mem_we_b_q   <= mem_we_b_d;
            mem_addr_b_q <= mem_addr_b_d;
            mem_data_b_q <= mem_data_b_d;
            tag_a_q      <= tag_a_d;
            tag_b_q      <= tag_b_d;
            tag2_a_q     <= tag_a_q;
            tag2_b_q     <= tag_b_q;
        end
    end

`ifdef DPM_ARB_RR_EN
    // Pointer moves past the last requester granted this cycle.
    always_comb begin
        if (b_go_s) begin
            ptr_d = b_idx_s + 2'd1;
        end else if (a_found_s) begin
            ptr_d = a_idx_s + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Route returning memory data to the requester named by the delayed tag.
    always_comb begin
        rvalid_s = {NREQ{1'b0}};
        rdata_s  = {(NREQ*DW){1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (tag2_a_q[3] && tag2_a_q[2] && (tag2_a_q[1:0] == 2'(i))) begin
                rvalid_s[i]          = 1'b1;
                rdata_s[DW*i +: DW]  = mem_q_a;
            end else if (tag2_b_q[3] && tag2_b_q[2] && (tag2_b_q[1:0] == 2'(i))) begin
                rvalid_s[i]          = 1'b1;
                rdata_s[DW*i +: DW]  = mem_q_b;
            end else begin
                rvalid_s[i]          = 1'b0;
            end
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_s;
    assign rdata      = rdata_s;
    assign mem_we_a   = mem_we_a_q;
    assign mem_addr_a = mem_addr_a_q;
    assign mem_data_a = mem_data_a_q;
    assign mem_we_b   = mem_we_b_q;
    assign mem_addr_b = mem_addr_b_q;
    assign mem_data_b = mem_data_b_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Bench for dual_port_mem_arbiter: directed scenarios then random traffic, all checked
// against a queue-based arbitration model and a shadow copy of the memory contents.
module tb_dual_port_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, req_we;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic [7:0]  mem_data_a, mem_data_b, mem_q_a, mem_q_b;
    logic [5:0]  mem_addr_a, mem_addr_b;
    logic        mem_we_a, mem_we_b;
    logic        mem_clr;
    logic [7:0]  mem [64];

    int n_chk, n_pass, n_fail;

    // reference model state
    logic [3:0]  m_gnt, m_rv;
    logic [31:0] m_rdata;
    int          m_ptr;
    logic        cur_v [2];
    logic        cur_we [2];
    int          cur_idx [2];
    logic [5:0]  cur_addr [2];
    logic [7:0]  cur_data [2];
    logic [7:0]  ref_mem [64];

    dual_port_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b), .mem_addr_a(mem_addr_a),
        .mem_addr_b(mem_addr_b), .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
        .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
    );

    always #5 clk = ~clk;

    // 64x8 synchronous dual-port memory, read-before-write
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem_q_a <= 8'h00;
            mem_q_b <= 8'h00;
        end else begin
            if (mem_we_a) mem[mem_addr_a] <= mem_data_a;
            if (mem_we_b) mem[mem_addr_b] <= mem_data_b;
            mem_q_a <= mem[mem_addr_a];
            mem_q_b <= mem[mem_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
        req[i]              = 1'b1;
        req_we[i]           = we;
        req_addr[6*i +: 6]  = a;
        req_wdata[8*i +: 8] = d;
    endtask

    task automatic new_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 8'($urandom));
    endtask

    task automatic model_clear();
        m_gnt = 4'h0; m_rv = 4'h0; m_rdata = 32'h0; m_ptr = 0;
        for (int p = 0; p < 2; p++) begin
            cur_v[p] = 1'b0; cur_we[p] = 1'b0; cur_idx[p] = 0;
            cur_addr[p] = 6'h0; cur_data[p] = 8'h0;
        end
    endtask

    // What the DUT should show after the coming clock edge, from the current inputs
    task automatic model_edge();
        int elig[$];
        int i, a, b;
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_rv = 4'h0; m_rdata = 32'h0;
        for (int p = 0; p < 2; p++) begin
            if (cur_v[p] && !cur_we[p]) begin
                m_rv[cur_idx[p]] = 1'b1;
                m_rdata[8*cur_idx[p] +: 8] = ref_mem[cur_addr[p]];
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (cur_v[p] && cur_we[p]) ref_mem[cur_addr[p]] = cur_data[p];
        end
        for (int k = 0; k < 4; k++) begin
`ifdef DPM_ARB_RR_EN
            i = (m_ptr + k) % 4;
`else
            i = k;
`endif
            if (req[i] && !m_gnt[i]) elig.push_back(i);
        end
        a = (elig.size() > 0) ? elig[0] : 0;
        b = (elig.size() > 1) ? elig[1] : 0;
        cur_v[0] = elig.size() > 0;
        cur_v[1] = elig.size() > 1;
        if (cur_v[1] && req_addr[6*a +: 6] == req_addr[6*b +: 6] && (req_we[a] || req_we[b]))
            cur_v[1] = 1'b0;
        cur_idx[0] = a;
        cur_idx[1] = b;
        m_gnt = 4'h0;
        for (int p = 0; p < 2; p++) begin
            cur_we[p]   = cur_v[p] ? req_we[cur_idx[p]] : 1'b0;
            cur_addr[p] = cur_v[p] ? req_addr[6*cur_idx[p] +: 6] : 6'h0;
            cur_data[p] = cur_v[p] ? req_wdata[8*cur_idx[p] +: 8] : 8'h0;
            if (cur_v[p]) m_gnt[cur_idx[p]] = 1'b1;
        end
        if (cur_v[1]) m_ptr = (b + 1) % 4;
        else if (cur_v[0]) m_ptr = (a + 1) % 4;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt", {60'h0, gnt}, {60'h0, m_gnt});
        chk("rvalid", {60'h0, rvalid}, {60'h0, m_rv});
        chk("rdata", {32'h0, rdata}, {32'h0, m_rdata});
        chk("mem_a", {49'h0, mem_we_a, mem_addr_a, mem_data_a},
            {49'h0, cur_v[0] && cur_we[0], cur_addr[0], cur_data[0]});
        chk("mem_b", {49'h0, mem_we_b, mem_addr_b, mem_data_b},
            {49'h0, cur_v[1] && cur_we[1], cur_addr[1], cur_data[1]});
    endtask

    initial begin
        logic [3:0] rel;
        int lat1, lat2;
        n_chk = 0; n_pass = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0; mem_clr = 1'b1;
        req = 4'hF; req_we = 4'h0; req_addr = 24'h0; req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        model_clear();

        // reset held with all requests pending
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_gnt", {60'h0, gnt}, 64'h0);
            chk("rst_out", {rvalid, rdata, mem_we_a, mem_we_b, mem_addr_a, mem_addr_b,
                            mem_data_a, mem_data_b}, 64'h0);
        end
        mem_clr = 1'b0; rst_n = 1'b1; req = 4'h0;
        tick();

        // preload addrs 1..4 with 0x11..0x44
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 8'(8'h11 * (i + 1)));
        tick(); chk("pre_gnt01", {60'h0, gnt}, 64'h3);
        req[1:0] = 2'b00;
        tick(); chk("pre_gnt23", {60'h0, gnt}, 64'hC);
        req[3:2] = 2'b00;
        tick();

        // contention: four reads in one cycle
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(i + 1), 8'h00);
        tick(); chk("cont_gnt01", {60'h0, gnt}, 64'h3);
        req[1:0] = 2'b00;
        tick(); chk("cont_gnt23", {60'h0, gnt}, 64'hC);
        chk("cont_rv01", {60'h0, rvalid}, 64'h3);
        chk("cont_rd01", {48'h0, rdata[15:0]}, 64'h2211);
        req[3:2] = 2'b00;
        tick(); chk("cont_rv23", {60'h0, rvalid}, 64'hC);
        chk("cont_rd23", {48'h0, rdata[31:16]}, 64'h4433);
        tick();

        // single write then read on req0
        set_req(0, 1'b1, 6'd5, 8'hAA);
        tick(); chk("wr_gnt", {60'h0, gnt}, 64'h1);
        tick();
        set_req(0, 1'b0, 6'd5, 8'h00);
        tick(); chk("rd_gnt", {60'h0, gnt}, 64'h1);
        tick(); chk("rd_rvalid", {60'h0, rvalid}, 64'h1);
        chk("rd_data", {56'h0, rdata[7:0]}, 64'hAA);
        req[0] = 1'b0;
        tick();

        // same-address write/read collision
        set_req(1, 1'b1, 6'd9, 8'h5C);
        set_req(2, 1'b0, 6'd9, 8'h00);
        tick(); chk("col_gnt1", {60'h0, gnt}, 64'h2);
        req[1] = 1'b0;
        tick(); chk("col_gnt2", {60'h0, gnt}, 64'h4);
        req[2] = 1'b0;
        tick(); chk("col_rvalid", {60'h0, rvalid}, 64'h4);
        chk("col_data", {56'h0, rdata[23:16]}, 64'h5C);
        tick();

        // fairness: req0/req3 always asserted, req1/req2 request once
        set_req(0, 1'b0, 6'd10, 8'h00);
        set_req(3, 1'b0, 6'd10, 8'h00);
        set_req(1, 1'b0, 6'd11, 8'h00);
        set_req(2, 1'b0, 6'd12, 8'h00);
        lat1 = 99; lat2 = 99;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (gnt[1] && lat1 == 99) begin lat1 = c; req[1] = 1'b0; end
            if (gnt[2] && lat2 == 99) begin lat2 = c; req[2] = 1'b0; end
        end
        chk("fair_req1", {63'h0, lat1 <= 2}, 64'h1);
        chk("fair_req2", {63'h0, lat2 <= 2}, 64'h1);
        req = 4'h0;
        tick(); tick();

        // two reads from req2/req3, then reset while in flight
        set_req(2, 1'b0, 6'd1, 8'h00);
        set_req(3, 1'b0, 6'd2, 8'h00);
        tick(); chk("prio_gnt", {60'h0, gnt}, 64'hC);
`ifndef DPM_ARB_RR_EN
        chk("prio_port_a", {58'h0, mem_addr_a}, 64'd1);
        chk("prio_port_b", {58'h0, mem_addr_b}, 64'd2);
`endif
        rst_n = 1'b0; req = 4'h0;
        tick(); chk("rstmid_rv0", {60'h0, rvalid}, 64'h0);
        tick(); chk("rstmid_rv1", {60'h0, rvalid}, 64'h0);
        rst_n = 1'b1;
        tick();

        // random traffic, each requester honouring the hold/release protocol
        rel = 4'h0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_gnt[i]) begin
                    rel[i] = 1'b1;
                end else if (rel[i]) begin
                    rel[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 1) == 1) begin
                    new_req(i);
                end
            end
            tick();
        end
        req = 4'h0;
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dual_port_mem_arbiter.md
# dual_port_mem_arbiter

Four-requester scheduler in front of the 64x8 dual-port memory (`data_a/b`, `addr_a/b`, `we_a/b`, `q_a/q_b`). Each cycle it grants up to two pending requests, one on each memory port. It blocks same-address conflicts between the two ports and returns read data to the owning requester with a fixed latency. All memory-side signals are registered, so the memory sees clean single-owner transactions.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; fixed at 4 in this revision.
- `AW`, 6, memory address width.
- `DW`, 8, memory data width.

Ports:
- `clk`  in  1  rising-edge clock. One clock domain. Reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request valid per requester; held until `gnt` is seen.
- `req_we`  in  4  1 = write, 0 = read, per requester.
- `req_addr`  in  24  address of requester i at `[6*i +: 6]`.
- `req_wdata`  in  32  write data of requester i at `[8*i +: 8]`.
- `gnt`  out  4  one-cycle grant pulse per requester.
- `rvalid`  out  4  read-data valid pulse per requester.
- `rdata`  out  32  read data of requester i at `[8*i +: 8]`.
- `mem_data_a`, `mem_data_b`  out  8  to memory `data_a` / `data_b`.
- `mem_addr_a`, `mem_addr_b`  out  6  to memory `addr_a` / `addr_b`.
- `mem_we_a`, `mem_we_b`  out  1  to memory `we_a` / `we_b`.
- `mem_q_a`, `mem_q_b`  in  8  from memory `q_a` / `q_b`; valid one cycle after the address is presented.

## Operation
- Eligibility: requester i is eligible when `req[i]=1` and `gnt[i]=0`. A requester being granted this cycle is masked, so it cannot be re-granted on a stale `req`.
- Selection with `DPM_ARB_RR_EN` defined: scan starts at round-robin pointer `ptr` (2 bits) and wraps modulo 4.
  - Port A gets the first eligible requester found.
  - Port B gets the next eligible requester after it.
- Collision rule: if the A and B candidates have equal addresses and at least one of them writes, only A is granted. The B candidate stays pending and is rescanned the next cycle.
- Pointer update: when any grant is issued, `ptr` ← (index of the last granted requester + 1) mod 4. With no grants, `ptr` holds.
- Memory drive: `mem_*_a/b` registers load the winner's `addr`, `wdata` and `we`.
  - An unused port loads `we=0`, `addr=0`, `data=0`.
- Read return:
  - An owner tag (valid, index, is-read) per port is registered alongside the mem registers, then delayed one more cycle.
  - When the delayed tag is a read, `rvalid[idx]=1` and `rdata[8*idx+:8]` = `mem_q_a` or `mem_q_b` for the owning port.
  - All other `rdata` slices are 0.
- Writes produce no `rvalid`.
- Requester obligation: after sampling `gnt[i]=1`, the requester either drops `req[i]` or presents a new request in the following cycle.

## Timing
- Cycle N: `req` sampled and arbitration performed combinationally.
- Cycle N+1: `gnt` high for the winners; `mem_*` signals driven; the memory captures them at the end of N+1.
- Cycle N+2: `rvalid`/`rdata` valid for reads.
- Read latency is req-to-rvalid 2 cycles. Each requester can issue at most one request per 2 cycles; aggregate throughput is 2 per cycle.
- Reset values (async assert, sync deassert handled externally):
  - `gnt=0`, `rvalid=0`, `rdata=0`.
  - `mem_we_a/b=0`, `mem_addr_a/b=0`, `mem_data_a/b=0`.
  - `ptr=0`, all tags invalid.
- Reset mid-operation: in-flight tags are discarded, so no `rvalid` is issued for them. Writes already registered may or may not complete in memory; requesters must re-issue them.
- Simultaneous read+read to the same address is not a collision: both ports are granted.

## Configuration
- `DPM_ARB_RR_EN` defined: round-robin selection from `ptr` as above.
- `DPM_ARB_RR_EN` undefined: fixed priority, requester 0 highest, 3 lowest.
  - Port A gets the lowest eligible index; port B gets the next lowest.
  - `ptr` is not implemented.
  - The collision rule is unchanged.

## Test plan
- Reset: hold `rst_n=0` with `req=4'hF` → all outputs 0, no `gnt` in any cycle while reset is asserted.
- Single write then read: req0 writes addr 5 with 0xAA. Two cycles later req0 reads addr 5 → `gnt[0]` one cycle after each request; `rvalid[0]` two cycles after the read request with `rdata[7:0]=0xAA`.
- Contention: all four requesters read distinct preloaded addrs 1–4 (0x11–0x44) in the same cycle.
  - With RR → grants {0,1} at N+1 and {2,3} at N+2.
  - Each `rvalid` arrives one cycle after its grant with the correct byte.
- Collision: req1 writes addr 9 = 0x5C and req2 reads addr 9 in the same cycle, `ptr=1`.
  - Only `gnt[1]` at N+1 and `gnt[2]` at N+2.
  - The read returns 0x5C.
- Fairness: req0 and req3 stay asserted continuously, re-requesting after every grant, while req1 and req2 request once → req1 and req2 are each granted within 2 cycles. `ptr` follows the last-granted+1 rule.
- Fixed priority build (macro undefined): req3 and req2 asserted together → port A is req2, port B is req3. Drop `rst_n` at N+1 → no `rvalid` is produced.
